// File: rtl/enc_pkg.sv
// Shared definitions for the sequential priority encoder:
// FSM state type, default vector width and index-width helper.
package enc_pkg;

    localparam int ENC_N_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } enc_state_e;

    // Index width for an n-bit vector; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lsb_first_enc.sv
// Combinational find-first-set: index of the lowest set bit of vec.
// Ports: vec (N) in; idx (W) out, 0 when vec is zero; any out, vec != 0.
module lsb_first_enc
    import enc_pkg::*;
#(
    parameter int N = ENC_N_DEFAULT,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top down so the lowest set bit is the last writer.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/prio_drain_encoder.sv
// Sequential priority encoder: accepts a multi-hot vector and emits the
// index of every set bit, LSB first, one per beat.
// Ports: clk, rst_n (sync, active low); in_valid/in_ready/in_vec input
// handshake; out_valid/out_ready/out_idx output handshake; zero_drop pulse
// for a discarded all-zero vector; out_last only when ENC_LAST_EN is defined.
module prio_drain_encoder
    import enc_pkg::*;
#(
    parameter int N = ENC_N_DEFAULT,
    parameter int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
`ifdef ENC_LAST_EN
    output logic         out_last,
`endif
    output logic         zero_drop
);

    enc_state_e   state;
    enc_state_e   state_nxt;
    logic [N-1:0] pend;
    logic [N-1:0] pend_nxt;
    logic [N-1:0] pend_rest;
    logic [W-1:0] low_idx;
    logic         any;
    logic         last_bit;
    logic         accept;
    logic         beat;

    lsb_first_enc #(
        .N(N),
        .W(W)
    ) u_enc (
        .vec(pend),
        .idx(low_idx),
        .any(any)
    );

    // pend with its lowest set bit cleared; zero means one bit was left.
    assign pend_rest = pend & (pend - N'(1));
    assign last_bit  = (pend_rest == '0);

    // Outputs are gated by rst_n so they read idle while reset is held.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = rst_n && (state == DRAIN) && any;
    assign out_idx   = rst_n ? low_idx : '0;

`ifdef ENC_LAST_EN
    assign out_last  = out_valid && last_bit;
`endif

    assign accept = in_valid && in_ready;
    assign beat   = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        unique case (state)
            IDLE: begin
                if (accept && (in_vec != '0)) begin
                    pend_nxt  = in_vec;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (beat) begin
                    pend_nxt = pend_rest;
                    if (last_bit) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= '0;
            zero_drop <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            zero_drop <= accept && (in_vec == '0);
        end
    end

endmodule

// File: tb/tb_prio_drain_encoder.sv
// Directed bench for prio_drain_encoder: vector table plus sequences for
// backpressure, zero vectors, mid-drain reset and back-to-back vectors.
module tb_prio_drain_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       zero_drop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prio_drain_encoder #(.N(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_vec(in_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx(out_idx),
`ifdef ENC_LAST_EN
        .out_last(out_last),
`endif
        .zero_drop(zero_drop)
    );

`ifndef ENC_LAST_EN
    assign out_last = 1'b0;
`endif

    typedef struct {
        logic [7:0]      vec;
        int              n;
        logic [7:0][2:0] idx;
    } vec_rec_t;

    vec_rec_t tbl[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_last(input string name, input logic exp);
`ifdef ENC_LAST_EN
        chk(name, int'(out_last), int'(exp));
`else
        if (exp === 1'bx) chk(name, int'(out_last), 0);
`endif
    endtask

    // Present one vector with out_ready high and check every beat.
    task automatic send(input vec_rec_t r);
        in_valid  = 1'b1;
        in_vec    = r.vec;
        out_ready = 1'b1;
        chk("in_ready_before", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        for (int b = 0; b < r.n; b++) begin
            chk("beat_valid", int'(out_valid), 1);
            chk("beat_idx", int'(out_idx), int'(r.idx[b]));
            chk_last("beat_last", (b == r.n - 1));
            chk("ready_in_drain", int'(in_ready), 0);
            step();
        end
        chk("idle_ready", int'(in_ready), 1);
        chk("idle_valid", int'(out_valid), 0);
    endtask

    initial begin
        tbl[0] = '{vec: 8'h04, n: 1, idx: 24'({3'd2})};
        tbl[1] = '{vec: 8'hA1, n: 3, idx: 24'({3'd7, 3'd5, 3'd0})};
        tbl[2] = '{vec: 8'hFF, n: 8,
                   idx: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
        tbl[3] = '{vec: 8'h3C, n: 4,
                   idx: 24'({3'd5, 3'd4, 3'd3, 3'd2})};
        tbl[4] = '{vec: 8'h81, n: 2, idx: 24'({3'd7, 3'd0})};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_zero_drop", int'(zero_drop), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", int'(in_ready), 1);

        for (int t = 0; t < 5; t++) begin
            send(tbl[t]);
        end

        // Backpressure: idx 1 must hold while out_ready is low.
        in_valid  = 1'b1;
        in_vec    = 8'h12;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_idx", int'(out_idx), 1);
            chk_last("bp_last", 1'b0);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_idx0", int'(out_idx), 1);
        step();
        chk("bp_rel_valid1", int'(out_valid), 1);
        chk("bp_rel_idx1", int'(out_idx), 4);
        chk_last("bp_rel_last1", 1'b1);
        step();
        chk("bp_idle", int'(out_valid), 0);

        // All-zero vector is dropped with a single pulse.
        in_valid = 1'b1;
        in_vec   = 8'h00;
        step();
        in_valid = 1'b0;
        chk("zd_pulse", int'(zero_drop), 1);
        chk("zd_valid", int'(out_valid), 0);
        chk("zd_ready", int'(in_ready), 1);
        step();
        chk("zd_clear", int'(zero_drop), 0);
        chk("zd_valid2", int'(out_valid), 0);

        // Reset in the middle of draining 8'hFF.
        in_valid = 1'b1;
        in_vec   = 8'hFF;
        step();
        in_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            chk("mr_idx", int'(out_idx), b);
            step();
        end
        rst_n = 1'b0;
        #1;
        chk("mr_valid_low", int'(out_valid), 0);
        chk("mr_ready_low", int'(in_ready), 0);
        chk("mr_idx_low", int'(out_idx), 0);
        step();
        chk("mr_valid_low2", int'(out_valid), 0);
        rst_n = 1'b1;
        #1;
        chk("mr_ready_rel", int'(in_ready), 1);
        chk("mr_valid_rel", int'(out_valid), 0);
        send('{vec: 8'h80, n: 1, idx: 24'({3'd7})});

        // Second vector held on in_valid during a three-beat drain.
        in_valid = 1'b1;
        in_vec   = 8'h07;
        step();
        in_vec = 8'h01;
        for (int b = 0; b < 3; b++) begin
            chk("ov_ready", int'(in_ready), 0);
            chk("ov_idx", int'(out_idx), b);
            step();
        end
        chk("ov_accept_ready", int'(in_ready), 1);
        chk("ov_gap_valid", int'(out_valid), 0);
        step();
        in_valid = 1'b0;
        chk("ov_second_valid", int'(out_valid), 1);
        chk("ov_second_idx", int'(out_idx), 0);
        chk_last("ov_second_last", 1'b1);
        step();
        chk("ov_done", int'(out_valid), 0);
        chk("ov_done_ready", int'(in_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
